// File: rtl/can_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared CAN definitions used by the bit de-stuffer and the frame decoder.
//   can_mode_e     : de-stuffer operating mode (encoding 3 is treated as bypass)
//   CAN_RECESSIVE  : logic level of a recessive bus bit
//   can_gray()     : binary to gray conversion, used on the FD stuff count
//   can_parity()   : even parity, used on the gray-coded FD stuff count
// -----------------------------------------------------------------------------
package can_pkg;

    typedef enum logic [1:0] {
        CAN_BYPASS  = 2'd0,
        CAN_DYNAMIC = 2'd1,
        CAN_FIXED   = 2'd2
    } can_mode_e;

    localparam logic CAN_RECESSIVE = 1'b1;

    // Wide enough for any stuff counter width in use; callers zero-extend.
    localparam int CAN_FN_W = 8;

    function automatic logic [CAN_FN_W-1:0] can_gray(input logic [CAN_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic can_parity(input logic [CAN_FN_W-1:0] val);
        return ^val;
    endfunction

endpackage

// File: rtl/can_destuff.sv
// -----------------------------------------------------------------------------
// can_destuff
// CAN / CAN FD bit de-stuffer placed between the bit-timing sampler and the
// frame decoder. On every sample strobe the received bit is either forwarded
// as a data bit or removed as an expected stuff bit; a stuff bit of the wrong
// polarity raises a stuff error. Modes: bypass, classic dynamic stuffing, and
// FD fixed-interval stuffing. Dynamic stuff bits are counted for the FD
// stuff-count field.
//
// Parameters
//   CONSEC    : equal-bit run length after which a dynamic stuff bit follows
//   FIXED_INT : data bits between fixed stuff bits in FIXED mode
//   CNT_W     : width of stuff_cnt
// Ports
//   clkin     in   system clock (posedge)
//   rstn      in   asynchronous active-low reset
//   clr       in   synchronous restart at SOF; wins over a coincident bit_vld
//   mode      in   0 bypass, 1 dynamic, 2 fixed, 3 bypass; sampled at bit_vld
//   bit_vld   in   one-cycle strobe at the sample point
//   bit_in    in   sampled bus bit (0 = dominant)
//   out_vld   out  strobe: out_bit carries a data bit
//   out_bit   out  de-stuffed data bit (holds between strobes)
//   stuff_vld out  strobe: a correct stuff bit was removed
//   err_p     out  strobe: stuff error on this bit
//   err       out  sticky stuff error, cleared by clr / rstn
//   stuff_cnt out  dynamic stuff bits removed since clr, wrapping
// All outputs are registered, one clkin cycle after bit_vld.
// -----------------------------------------------------------------------------
module can_destuff
    import can_pkg::*;
#(
    parameter int CONSEC    = 5,
    parameter int FIXED_INT = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             out_vld,
    output logic             out_bit,
    output logic             stuff_vld,
    output logic             err_p,
    output logic             err,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam logic [3:0] CONSEC_L    = 4'(CONSEC);
    localparam logic [3:0] FIXED_INT_L = 4'(FIXED_INT);

    // State
    logic             r_last;
    logic [3:0]       r_run;
    logic             r_expect;
    logic [3:0]       r_fcnt;
    can_mode_e        r_pmode;
    logic             r_err;
    logic [CNT_W-1:0] r_stuff_cnt;
    logic             r_out_vld;
    logic             r_out_bit;
    logic             r_stuff_vld;
    logic             r_err_p;

    // Next-state
    logic             w_last_next;
    logic [3:0]       w_run_next;
    logic             w_expect_next;
    logic [3:0]       w_fcnt_next;
    can_mode_e        w_pmode_next;
    logic             w_err_next;
    logic [CNT_W-1:0] w_stuff_cnt_next;
    logic             w_out_vld_next;
    logic             w_out_bit_next;
    logic             w_stuff_vld_next;
    logic             w_err_p_next;

    can_mode_e        w_mode;
    logic [3:0]       w_run_inc;
    logic             w_polarity_ok;

    // Encoding 3 is not a real mode and behaves like bypass.
    assign w_mode = (mode == 2'd3) ? CAN_BYPASS : can_mode_e'(mode);

    // Run length including the current bit; saturates so a stale run carried
    // in from another mode can never wrap back into range.
    assign w_run_inc = (bit_in != r_last) ? 4'd1 :
                       (r_run == 4'hF)    ? r_run : (r_run + 4'd1);

    // A stuff bit must have the opposite polarity to the previous bus bit.
    assign w_polarity_ok = (bit_in != r_last);

    always_comb begin
        w_last_next      = r_last;
        w_run_next       = r_run;
        w_expect_next    = r_expect;
        w_fcnt_next      = r_fcnt;
        w_pmode_next     = r_pmode;
        w_err_next       = r_err;
        w_stuff_cnt_next = r_stuff_cnt;
        w_out_vld_next   = 1'b0;
        w_out_bit_next   = r_out_bit;
        w_stuff_vld_next = 1'b0;
        w_err_p_next     = 1'b0;

        if (clr) begin
            w_last_next      = CAN_RECESSIVE;
            w_run_next       = 4'd0;
            w_expect_next    = 1'b0;
            w_fcnt_next      = 4'd0;
            w_pmode_next     = CAN_BYPASS;
            w_err_next       = 1'b0;
            w_stuff_cnt_next = '0;
            w_out_bit_next   = CAN_RECESSIVE;
        end else if (bit_vld) begin
            w_pmode_next = w_mode;
            w_last_next  = bit_in;

            case (w_mode)
                CAN_DYNAMIC: begin
                    w_fcnt_next = 4'd0;
                    // A pending stuff expectation only survives if we stayed
                    // in dynamic mode.
                    if (r_expect && (r_pmode == CAN_DYNAMIC)) begin
                        if (w_polarity_ok) begin
                            w_stuff_vld_next = 1'b1;
                            w_stuff_cnt_next = r_stuff_cnt + 1'b1;
                        end else begin
                            w_err_p_next = 1'b1;
                            w_err_next   = 1'b1;
                        end
                        // The stuff bit itself starts the next run.
                        w_run_next    = 4'd1;
                        w_expect_next = 1'b0;
                    end else begin
                        w_out_vld_next = 1'b1;
                        w_out_bit_next = bit_in;
                        w_run_next     = w_run_inc;
                        w_expect_next  = (w_run_inc == CONSEC_L);
                    end
                end

                CAN_FIXED: begin
                    w_expect_next = 1'b0;
                    // The first bit after entering FIXED is a stuff bit.
                    if ((r_pmode != CAN_FIXED) || (r_fcnt == FIXED_INT_L)) begin
                        if (w_polarity_ok) begin
                            w_stuff_vld_next = 1'b1;
                        end else begin
                            w_err_p_next = 1'b1;
                            w_err_next   = 1'b1;
                        end
                        w_fcnt_next = 4'd0;
                    end else begin
                        w_out_vld_next = 1'b1;
                        w_out_bit_next = bit_in;
                        w_fcnt_next    = r_fcnt + 4'd1;
                    end
                end

                default: begin
                    w_out_vld_next = 1'b1;
                    w_out_bit_next = bit_in;
                    w_run_next     = 4'd1;
                    w_expect_next  = 1'b0;
                    w_fcnt_next    = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_last      <= CAN_RECESSIVE;
            r_run       <= 4'd0;
            r_expect    <= 1'b0;
            r_fcnt      <= 4'd0;
            r_pmode     <= CAN_BYPASS;
            r_err       <= 1'b0;
            r_stuff_cnt <= '0;
            r_out_vld   <= 1'b0;
            r_out_bit   <= CAN_RECESSIVE;
            r_stuff_vld <= 1'b0;
            r_err_p     <= 1'b0;
        end else begin
            r_last      <= w_last_next;
            r_run       <= w_run_next;
            r_expect    <= w_expect_next;
            r_fcnt      <= w_fcnt_next;
            r_pmode     <= w_pmode_next;
            r_err       <= w_err_next;
            r_stuff_cnt <= w_stuff_cnt_next;
            r_out_vld   <= w_out_vld_next;
            r_out_bit   <= w_out_bit_next;
            r_stuff_vld <= w_stuff_vld_next;
            r_err_p     <= w_err_p_next;
        end
    end

    assign out_vld   = r_out_vld;
    assign out_bit   = r_out_bit;
    assign stuff_vld = r_stuff_vld;
    assign err_p     = r_err_p;
    assign err       = r_err;
    assign stuff_cnt = r_stuff_cnt;

endmodule

// File: tb/tb_can_destuff.sv
// -----------------------------------------------------------------------------
// tb_can_destuff
// Directed bench for can_destuff (CONSEC=5, FIXED_INT=4, CNT_W=3).
// -----------------------------------------------------------------------------
module tb_can_destuff;

    logic       clkin;
    logic       rstn;
    logic       clr;
    logic [1:0] mode;
    logic       bit_vld;
    logic       bit_in;
    logic       out_vld;
    logic       out_bit;
    logic       stuff_vld;
    logic       err_p;
    logic       err;
    logic [2:0] stuff_cnt;

    int n_checks = 0;
    int n_errors = 0;

    can_destuff #(
        .CONSEC   (5),
        .FIXED_INT(4),
        .CNT_W    (3)
    ) dut (
        .clkin    (clkin),
        .rstn     (rstn),
        .clr      (clr),
        .mode     (mode),
        .bit_vld  (bit_vld),
        .bit_in   (bit_in),
        .out_vld  (out_vld),
        .out_bit  (out_bit),
        .stuff_vld(stuff_vld),
        .err_p    (err_p),
        .err      (err),
        .stuff_cnt(stuff_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit_vld cycle; outputs are sampled 1 time unit after the edge that
    // registers the strobe. Consecutive calls give back-to-back strobes.
    task automatic send(input logic b, input logic e_ov, input logic e_sv,
                        input logic e_ep, input string tag);
        bit_in  = b;
        bit_vld = 1'b1;
        @(posedge clkin);
        #1;
        bit_vld = 1'b0;
        chk({tag, ".out_vld"},   8'(out_vld),   8'(e_ov));
        chk({tag, ".stuff_vld"}, 8'(stuff_vld), 8'(e_sv));
        chk({tag, ".err_p"},     8'(err_p),     8'(e_ep));
        if (e_ov) chk({tag, ".out_bit"}, 8'(out_bit), 8'(b));
        $display("bit %0d mode %0d -> ov=%0d ob=%0d sv=%0d ep=%0d err=%0d cnt=%0d [%s]",
                 b, mode, out_vld, out_bit, stuff_vld, err_p, err, stuff_cnt, tag);
    endtask

    task automatic idle(input string tag);
        @(posedge clkin);
        #1;
        chk({tag, ".idle_strobes"}, 8'({out_vld, stuff_vld, err_p}), 8'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clkin);
        #1;
        clr = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".out_vld"},   8'(out_vld),   8'd0);
        chk({tag, ".out_bit"},   8'(out_bit),   8'd1);
        chk({tag, ".stuff_vld"}, 8'(stuff_vld), 8'd0);
        chk({tag, ".err_p"},     8'(err_p),     8'd0);
        chk({tag, ".err"},       8'(err),       8'd0);
        chk({tag, ".stuff_cnt"}, 8'(stuff_cnt), 8'd0);
    endtask

    initial begin
        logic v;
        rstn    = 1'b0;
        clr     = 1'b0;
        mode    = 2'd1;
        bit_vld = 1'b0;
        bit_in  = 1'b1;

        // Reset state
        repeat (2) @(posedge clkin);
        #1;
        chk_reset_vals("reset");
        rstn = 1'b1;

        // Mode 3 behaves as bypass: six equal bits all forwarded
        mode = 2'd3;
        do_clr();
        for (int i = 0; i < 6; i++) send(1'b1, 1, 0, 0, "byp3");
        idle("byp3");

        // DYNAMIC: 0,0,0,0,0,1,0
        mode = 2'd1;
        do_clr();
        for (int i = 0; i < 5; i++) send(1'b0, 1, 0, 0, "dyn_a");
        send(1'b1, 0, 1, 0, "dyn_a_stuff");
        send(1'b0, 1, 0, 0, "dyn_a_after");
        chk("dyn_a.stuff_cnt", 8'(stuff_cnt), 8'd1);
        chk("dyn_a.err", 8'(err), 8'd0);
        idle("dyn_a");

        // DYNAMIC: six 1s after clr -> error on the sixth, sticky
        do_clr();
        for (int i = 0; i < 5; i++) send(1'b1, 1, 0, 0, "dyn_b");
        send(1'b1, 0, 0, 1, "dyn_b_err");
        chk("dyn_b.err", 8'(err), 8'd1);
        idle("dyn_b");
        send(1'b0, 1, 0, 0, "dyn_b_recover");
        chk("dyn_b.err_sticky", 8'(err), 8'd1);
        do_clr();
        chk("dyn_b.err_clr", 8'(err), 8'd0);

        // DYNAMIC: the stuff bit starts the next run
        // 1x5, stuff 0, 0x4 (run 5 with the stuff bit), stuff 1
        for (int i = 0; i < 5; i++) send(1'b1, 1, 0, 0, "dyn_c");
        send(1'b0, 0, 1, 0, "dyn_c_stuff1");
        for (int i = 0; i < 4; i++) send(1'b0, 1, 0, 0, "dyn_c_run");
        send(1'b1, 0, 1, 0, "dyn_c_stuff2");
        chk("dyn_c.stuff_cnt", 8'(stuff_cnt), 8'd2);

        // FIXED: last=0, entry stuff 1, four data bits, stuff, four data, bad stuff
        send(1'b0, 1, 0, 0, "fix_pre");
        mode = 2'd2;
        send(1'b1, 0, 1, 0, "fix_entry");
        send(1'b1, 1, 0, 0, "fix_d1");
        send(1'b0, 1, 0, 0, "fix_d2");
        send(1'b1, 1, 0, 0, "fix_d3");
        send(1'b1, 1, 0, 0, "fix_d4");
        send(1'b0, 0, 1, 0, "fix_stuff");
        chk("fix.stuff_cnt", 8'(stuff_cnt), 8'd2);
        chk("fix.err", 8'(err), 8'd0);
        send(1'b0, 1, 0, 0, "fix_d5");
        send(1'b0, 1, 0, 0, "fix_d6");
        send(1'b1, 1, 0, 0, "fix_d7");
        send(1'b1, 1, 0, 0, "fix_d8");
        send(1'b1, 0, 0, 1, "fix_bad_stuff");
        chk("fix.err", 8'(err), 8'd1);
        chk("fix.stuff_cnt_hold", 8'(stuff_cnt), 8'd2);

        // clr coincident with bit_vld: bit discarded, outputs at reset values
        clr     = 1'b1;
        bit_vld = 1'b1;
        bit_in  = 1'b0;
        @(posedge clkin);
        #1;
        clr     = 1'b0;
        bit_vld = 1'b0;
        chk_reset_vals("clr_bitvld");

        // DYNAMIC: eight stuff bits back-to-back, counter wraps at 8
        mode = 2'd1;
        for (int i = 0; i < 5; i++) send(1'b0, 1, 0, 0, "wrap_g0");
        send(1'b1, 0, 1, 0, "wrap_s0");
        v = 1'b1;
        for (int k = 1; k < 8; k++) begin
            for (int i = 0; i < 4; i++) send(v, 1, 0, 0, "wrap_run");
            send(~v, 0, 1, 0, "wrap_stuff");
            chk("wrap.stuff_cnt", 8'(stuff_cnt), 8'((k + 1) % 8));
            v = ~v;
        end
        chk("wrap.stuff_cnt_zero", 8'(stuff_cnt), 8'd0);
        for (int i = 0; i < 4; i++) send(v, 1, 0, 0, "wrap_run9");
        send(~v, 0, 1, 0, "wrap_stuff9");
        chk("wrap.stuff_cnt_9", 8'(stuff_cnt), 8'd1);
        v = ~v;

        // rstn asserted mid-run together with a bit strobe
        send(v, 1, 0, 0, "mid_run");
        rstn    = 1'b0;
        bit_vld = 1'b1;
        bit_in  = 1'b0;
        @(posedge clkin);
        #1;
        bit_vld = 1'b0;
        chk_reset_vals("rst_mid");
        rstn = 1'b1;
        do_clr();
        send(1'b0, 1, 0, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
